// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: mult/div funct codes and sequencer states.
package mips_defs_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } mdState_t;

  function automatic logic isMulDiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of shift-add multiply or restoring divide.
module mul_div_step
  import mips_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] md,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] mqNext
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, md};
    rem     = {acc, mq[WIDTH-1]};
    diff    = rem - {1'b0, md};
    accNext = acc;
    mqNext  = mq;
    if (isDiv) begin
      // Borrow out of the 33-bit subtract means restore.
      if (!diff[WIDTH]) begin
        accNext = diff[WIDTH-1:0];
        mqNext  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        accNext = rem[WIDTH-1:0];
        mqNext  = {mq[WIDTH-2:0], 1'b0};
      end
    end else if (mq[0]) begin
      {accNext, mqNext} = {sum, mq[WIDTH-1:1]};
    end else begin
      {accNext, mqNext} = {1'b0, acc, mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative mult/div sequencer owning HI/LO; 32 steps plus a sign-fix cycle.
module mul_div_sequencer
  import mips_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdState_t         state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] md;
  logic             isDiv;
  logic             negQ;
  logic             negR;
  logic             divzR;

  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] mqNext;

  logic             opSigned;
  logic             rsNeg;
  logic             rtNeg;
  logic [WIDTH-1:0] rsMag;
  logic [WIDTH-1:0] rtMag;
  logic             opDiv;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  mul_div_step #(.WIDTH(WIDTH)) uStep (
    .isDiv   (isDiv),
    .acc     (acc),
    .mq      (mq),
    .md      (md),
    .accNext (accNext),
    .mqNext  (mqNext)
  );

  always_comb begin
    opSigned = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    opDiv    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    rsNeg    = opSigned & ReadData1[WIDTH-1];
    rtNeg    = opSigned & ReadData2[WIDTH-1];
    rsMag    = rsNeg ? -ReadData1 : ReadData1;
    rtMag    = rtNeg ? -ReadData2 : ReadData2;
  end

  always_comb begin
    prod  = {acc, mq};
    prod  = negQ ? -prod : prod;
    fixHi = prod[2*WIDTH-1:WIDTH];
    fixLo = prod[WIDTH-1:0];
    if (isDiv) begin
      fixHi = negR ? -acc : acc;
      fixLo = divzR ? DIVZ_LO : (negQ ? -mq : mq);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      md    <= '0;
      isDiv <= 1'b0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
      divzR <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      divz  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      divz <= 1'b0;
      if (flush) begin
        state <= MD_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          MD_IDLE: begin
            if (start) begin
              unique case (1'b1)
                isMulDiv(funct): begin
                  acc   <= '0;
                  mq    <= opDiv ? rsMag : rtMag;
                  md    <= opDiv ? rtMag : rsMag;
                  isDiv <= opDiv;
                  negQ  <= rsNeg ^ rtNeg;
                  negR  <= rsNeg;
                  divzR <= opDiv && (ReadData2 == '0);
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= MD_CALC;
                end
                (funct == FUNCT_MTHI): hi <= ReadData1;
                (funct == FUNCT_MTLO): lo <= ReadData1;
                default: ;
              endcase
            end
          end
          MD_CALC: begin
            acc <= accNext;
            mq  <= mqNext;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(WIDTH - 1)) state <= MD_FIX;
          end
          MD_FIX: begin
            hi    <= fixHi;
            lo    <= fixLo;
            done  <= 1'b1;
            divz  <= divzR;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end
          default: state <= MD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: vector table plus corner sequences.
`timescale 1ns/1ps
module tb_mul_div_sequencer;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  funct = 6'h0;
  logic [31:0] rd1 = 32'h0;
  logic [31:0] rd2 = 32'h0;
  logic        busy;
  logic        done;
  logic        divz;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .funct     (funct),
    .ReadData1 (rd1),
    .ReadData2 (rd2),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .divz      (divz),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] eHi;
    logic [31:0] eLo;
    logic        eDivz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divz;
  } res_t;

  res_t        sb[$];
  vec_t        vecs[10];
  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] mHi = 32'h0;
  logic [31:0] mLo = 32'h0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input bit push,
                        input res_t e);
    start = 1'b1;
    funct = f;
    rd1   = rs;
    rd2   = rt;
    if (push) sb.push_back(e);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int injectAt);
    int   edges;
    int   busyCnt;
    res_t e;
    edges   = 0;
    busyCnt = 0;
    while (!done && edges < 40) begin
      if (busy) busyCnt++;
      if (injectAt != 0 && edges == injectAt) begin
        start = 1'b1;
        funct = F_DIVU;
        rd1   = 32'd99;
        rd2   = 32'd5;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      edges++;
    end
    chk({name, " latency"}, edges, 33);
    chk({name, " busyCycles"}, busyCnt, 33);
    chk({name, " busyInDone"}, {31'b0, busy}, 0);
    if (sb.size() == 0) begin
      chk({name, " scoreboardEmpty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      if (done) begin
        chk({name, " hi"}, hi, e.hi);
        chk({name, " lo"}, lo, e.lo);
        chk({name, " divz"}, {31'b0, divz}, {31'b0, e.divz});
        mHi = e.hi;
        mLo = e.lo;
      end
    end
    @(posedge clock);
    #1;
    chk({name, " donePulse"}, {31'b0, done}, 0);
    chk({name, " divzPulse"}, {31'b0, divz}, 0);
  endtask

  initial begin
    res_t e;
    int   doneSeen;

    repeat (2) @(posedge clock);
    #1;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset divz", {31'b0, divz}, 0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{F_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
    vecs[5] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7] = '{F_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{F_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[9] = '{F_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0};

    for (int i = 0; i < 10; i++) begin
      e.hi   = vecs[i].eHi;
      e.lo   = vecs[i].eLo;
      e.divz = vecs[i].eDivz;
      launch(vecs[i].f, vecs[i].rs, vecs[i].rt, 1'b1, e);
      waitDone($sformatf("vec%0d", i), 0);
    end

    launch(F_MTHI, 32'h1234, 32'h0, 1'b0, e);
    chk("mthi hi", hi, 32'h1234);
    chk("mthi lo", lo, mLo);
    chk("mthi busy", {31'b0, busy}, 0);
    chk("mthi done", {31'b0, done}, 0);
    mHi = 32'h1234;
    launch(F_MTLO, 32'hCAFE0001, 32'h0, 1'b0, e);
    chk("mtlo lo", lo, 32'hCAFE0001);
    chk("mtlo hi", hi, mHi);
    mLo = 32'hCAFE0001;

    e = '{32'h00000001, 32'h00000000, 1'b0};
    launch(F_MULTU, 32'h00010000, 32'h00010000, 1'b1, e);
    waitDone("startWhileBusy", 10);

    launch(F_MULT, 32'd3, 32'd5, 1'b0, e);
    repeat (19) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) doneSeen++;
      @(posedge clock);
      #1;
    end
    chk("flush noDone", doneSeen, 0);
    chk("flush hi", hi, mHi);
    chk("flush lo", lo, mLo);

    flush = 1'b1;
    launch(F_MTHI, 32'hDEAD, 32'h0, 1'b0, e);
    flush = 1'b0;
    chk("flushStart busy", {31'b0, busy}, 0);
    chk("flushStart hi", hi, mHi);

    launch(F_DIV, 32'd100, 32'hFFFFFFFD, 1'b0, e);
    repeat (14) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    chk("asyncRst hi", hi, 0);
    chk("asyncRst lo", lo, 0);
    chk("asyncRst busy", {31'b0, busy}, 0);
    mHi = 32'h0;
    mLo = 32'h0;
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    e = '{32'd2, 32'd14, 1'b0};
    launch(F_DIVU, 32'd100, 32'd7, 1'b1, e);
    waitDone("afterReset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
